// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with optional return-address stack.
// Optional feature macro: PC_SEQUENCER_RAS_EN
//   defined   -> circular LIFO return-address stack of RAS_DEPTH entries
//   undefined -> no stack; CALL acts as JUMP, RET acts as SEQ, ras_count/ras_err tied 0
// All outputs come straight from registers; next-state logic is purely combinational.
module pc_sequencer #(
  parameter int unsigned       WIDTH      = 32,
  parameter int unsigned       STEP       = 4,
  parameter logic [WIDTH-1:0]  RESET_ADDR = '0,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic [2:0]                 op,
  input  logic                       taken,
  input  logic [WIDTH-1:0]           offset,
  input  logic [WIDTH-1:0]           target,
  output logic [WIDTH-1:0]           pc_out,
  output logic [$clog2(RAS_DEPTH):0] ras_count,
  output logic                       ras_err
);

  localparam int unsigned SW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = SW + 1;

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic [2:0] {
    OP_SEQ    = 3'b000,
    OP_BRANCH = 3'b001,
    OP_JUMP   = 3'b010,
    OP_CALL   = 3'b011,
    OP_RET    = 3'b100
  } op_e;

  op_e              op_q;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_br;
  logic [WIDTH-1:0] pc_next;

  assign op_q = op_e'(op);

  // Candidate addresses; sums wrap modulo 2^WIDTH by truncation.
  always_comb begin
    pc_seq = pc_out + STEP_W;
    pc_br  = pc_out + offset;
  end

`ifdef PC_SEQUENCER_RAS_EN

  localparam logic [SW-1:0] SP_ONE  = SW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  // Entries are never reset: they are unreachable while ras_count is 0.
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  // sp points at the next slot to write; when full it points at the oldest entry,
  // so a push on a full stack overwrites the oldest return address.
  logic [SW-1:0]    sp;
  logic [SW-1:0]    sp_top;
  logic [WIDTH-1:0] ras_top;
  logic             ras_full;
  logic             ras_empty;
  logic             do_push;
  logic             do_pop;

  // Stack status and top-of-stack read.
  always_comb begin
    sp_top    = sp - SP_ONE;
    ras_top   = ras_mem[sp_top];
    ras_full  = (ras_count == CNT_MAX);
    ras_empty = (ras_count == '0);
    do_push   = !stall && (op_q == OP_CALL);
    do_pop    = !stall && (op_q == OP_RET) && !ras_empty;
  end

  // Next PC selection with stack-aware RET.
  always_comb begin
    pc_next = pc_seq;
    unique case (op_q)
      OP_BRANCH: pc_next = taken ? pc_br : pc_seq;
      OP_JUMP:   pc_next = target;
      OP_CALL:   pc_next = target;
      OP_RET:    pc_next = ras_empty ? pc_seq : ras_top;
      default:   pc_next = pc_seq;
    endcase
  end

  // Stack storage write; gated by reset so a CALL coinciding with reset leaves no trace.
  always_ff @(posedge clk) begin
    if (reset && do_push)
      ras_mem[sp] <= pc_seq;
  end

  // PC, stack pointer, occupancy and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_out    <= RESET_ADDR;
      sp        <= '0;
      ras_count <= '0;
      ras_err   <= 1'b0;
    end else if (stall) begin
      ras_err   <= 1'b0;
    end else begin
      pc_out  <= pc_next;
      ras_err <= 1'b0;
      if (do_push) begin
        sp <= sp + SP_ONE;
        if (ras_full) ras_err   <= 1'b1;
        else          ras_count <= ras_count + CNT_ONE;
      end else if (op_q == OP_RET) begin
        if (ras_empty) begin
          ras_err <= 1'b1;
        end else begin
          sp        <= sp_top;
          ras_count <= ras_count - CNT_ONE;
        end
      end
    end
  end

  // do_pop is folded into the RET branch above; kept as a named term for readability.
  logic unused_pop;
  assign unused_pop = do_pop;

`else

  // Next PC selection without a stack: CALL jumps, RET falls through.
  always_comb begin
    pc_next = pc_seq;
    unique case (op_q)
      OP_BRANCH: pc_next = taken ? pc_br : pc_seq;
      OP_JUMP:   pc_next = target;
      OP_CALL:   pc_next = target;
      default:   pc_next = pc_seq;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      pc_out <= RESET_ADDR;
    else if (!stall) pc_out <= pc_next;
  end

  assign ras_count = '0;
  assign ras_err   = 1'b0;

`endif

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: PC, target and offset width in bits.
REQ-002 Parameter STEP, default 4: sequential increment added to PC.
REQ-003 Parameter RESET_ADDR, default 0: PC value loaded on reset.
REQ-004 Parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, minimum 2.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 stall  input  1  high holds all state for the current cycle.
REQ-008 op  input  3  operation: 000 SEQ, 001 BRANCH, 010 JUMP, 011 CALL, 100 RET, 101-111 reserved.
REQ-009 taken  input  1  branch condition, used only by BRANCH.
REQ-010 offset  input  WIDTH  two's-complement branch displacement.
REQ-011 target  input  WIDTH  absolute address for JUMP and CALL.
REQ-012 pc_out  output  WIDTH  current PC, driven directly from a register.
REQ-013 ras_count  output  $clog2(RAS_DEPTH)+1  number of valid stack entries.
REQ-014 ras_err  output  1  one-cycle pulse on stack overflow or underflow.

Function
REQ-015 Unstalled rising edge, PC next value:
  - SEQ: pc+STEP.
  - BRANCH: pc+offset if taken=1, else pc+STEP.
  - JUMP: target.
  - CALL: target.
  - RET: popped stack entry.
  - Reserved opcodes: same as SEQ.
REQ-016 All PC arithmetic is modulo 2^WIDTH; carry is discarded, so 0xFFFFFFFC+4 gives 0 at WIDTH=32.
REQ-017 Edge with stall=1: pc_out, stack contents and ras_count hold; ras_err is 0 on the next cycle; op is ignored.
REQ-018 Latency: the effect of op is visible on pc_out one cycle after the sampling edge; no combinational path from inputs to outputs.
REQ-019 CALL pushes pc+STEP (modulo 2^WIDTH) onto the stack and increments ras_count.
REQ-020 CALL with ras_count=RAS_DEPTH: overwrites the oldest entry (circular), ras_count stays RAS_DEPTH, ras_err=1 for one cycle, PC still loads target.
REQ-021 RET with ras_count>0: PC loads the most recent entry and ras_count decrements.
REQ-022 RET with ras_count=0: PC loads pc+STEP, ras_count stays 0, ras_err=1 for one cycle.
REQ-023 ras_err is registered; it is 1 only in the cycle after the offending edge, otherwise 0.
REQ-024 Stack is LIFO, with pointer wrap-around modulo RAS_DEPTH; push and pop never occur on the same edge.

Reset
REQ-025 reset=0 immediately, without waiting for a clock edge, forces:
  - pc_out=RESET_ADDR;
  - ras_count=0;
  - ras_err=0;
  - stack pointer to 0.
REQ-026 Stack entry contents need not be cleared on reset; they are unreachable while ras_count=0.
REQ-027 While reset=0, stall and op have no effect; the first update occurs on the first rising edge after reset returns high.
REQ-028 Reset asserted mid-sequence, including in the same cycle as a CALL or RET, discards that operation entirely.

Configuration
REQ-029 Macro PC_SEQUENCER_RAS_EN defined: return-address stack present; behaviour as REQ-019 to REQ-024.
REQ-030 Macro PC_SEQUENCER_RAS_EN undefined:
  - no stack storage is synthesised;
  - CALL behaves as JUMP;
  - RET behaves as SEQ;
  - ras_count is tied to 0 and ras_err to 0;
  - port list is unchanged.

Verification
REQ-031 Reset, then 3 unstalled SEQ edges with RESET_ADDR=0, STEP=4 -> pc_out 0, 4, 8, 12; asynchronous reset low mid-cycle -> pc_out=0 before the next edge.
REQ-032 pc=0x100, BRANCH taken=1 offset=0xFFFFFFF0 -> 0xF0; BRANCH taken=0 -> 0xF4; JUMP target=0x2000 -> 0x2000.
REQ-033 pc=0x40, CALL target=0x800 -> pc=0x800, ras_count=1; then SEQ -> 0x804; then RET -> 0x44, ras_count=0.
REQ-034 RAS_DEPTH=4, 5 CALLs from pcs 0x0, 0x10, 0x20, 0x30, 0x40 -> ras_err pulses once after the 5th, ras_count=4; 4 RETs return 0x44, 0x34, 0x24, 0x14; a 5th RET -> pc+4 with ras_err=1.
REQ-035 stall=1 held 3 cycles with op=JUMP target=0x999 -> pc_out and ras_count unchanged; pc=0xFFFFFFFC SEQ -> 0x0.
REQ-036 Build with PC_SEQUENCER_RAS_EN undefined, pc=0x40: CALL target=0x800 -> 0x800; RET -> 0x804; ras_count and ras_err stay 0 throughout.
